// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises and deglitches kclock/kdata, deserialises 11-bit frames, keeps a 32-bit scan-code history.
// Latency: keycode_valid one clock after the filtered stop-bit fall; no backpressure, every good byte is shifted in unconditionally.

module ps2_line_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_line,
    output logic o_level
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [FW-1:0] r_cnt;

    // The level only moves once the new value has been seen FILTER_CYCLES clocks in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == FW'(FILTER_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + FW'(1);
            end
        end
    end

    assign o_level = r_level;
endmodule

module ps2_receiver #(
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        kclock,
    input  logic        kdata,
    output logic [31:0] keycodeout,
    output logic        keycode_valid,
    output logic        frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    w_bit_cnt_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_par;
    logic          w_par_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic [TW-1:0] w_tmo_cnt_nxt;
    logic [31:0]   r_keycode;
    logic          r_valid;
    logic          r_error;
    logic          w_ok;
    logic          w_err;
    logic          w_tmo;
    logic          w_kclk;
    logic          w_kdat;
    logic          r_kclk_prev;
    logic          w_fall;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_kclk_filter (
        .clock   (clock),
        .reset   (reset),
        .i_line  (kclock),
        .o_level (w_kclk)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_kdat_filter (
        .clock   (clock),
        .reset   (reset),
        .i_line  (kdata),
        .o_level (w_kdat)
    );

    assign w_fall = r_kclk_prev & ~w_kclk;
    assign w_tmo  = (r_state != IDLE) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout is checked first so a fall coinciding with expiry is dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_ok          = 1'b0;
        w_err         = 1'b0;
        if (w_tmo) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_kdat) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_nxt   = {w_kdat, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_par_nxt   = w_kdat;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_kdat && (^{r_shift, r_par})) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        if ((r_state == IDLE) || w_tmo || w_fall) begin
            w_tmo_cnt_nxt = '0;
        end else begin
            w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_kclk_prev <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_par       <= 1'b0;
            r_tmo_cnt   <= '0;
            r_keycode   <= 32'd0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_kclk_prev <= w_kclk;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par       <= w_par_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_valid     <= w_ok;
            r_error     <= w_err;
            if (w_ok) begin
                r_keycode <= {r_keycode[23:0], r_shift};
            end
        end
    end

    assign keycodeout    = r_keycode;
    assign keycode_valid = r_valid;
    assign frame_error   = r_error;
endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: directed frames plus randomized frames, glitches, bad parity/stop and timeouts.
module tb_ps2_receiver;
    localparam int TMO = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        kclock = 1'b1;
    logic        kdata = 1'b1;
    logic [31:0] keycodeout;
    logic        keycode_valid;
    logic        frame_error;

    typedef struct packed {
        logic        err;
        logic [31:0] kc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] m_hist = 32'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    ps2_receiver #(.FILTER_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clock         (clock),
        .reset         (reset),
        .kclock        (kclock),
        .kdata         (kdata),
        .keycodeout    (keycodeout),
        .keycode_valid (keycode_valid),
        .frame_error   (frame_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && (keycode_valid || frame_error)) begin
            check("pulse_exclusive", {31'd0, keycode_valid & frame_error}, 32'd0);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%b error=%b keycodeout=%h, nothing expected",
                         keycode_valid, frame_error, keycodeout);
            end else begin
                mon_e = q.pop_front();
                check("pulse_kind_error", {31'd0, frame_error}, {31'd0, mon_e.err});
                check("keycodeout", keycodeout, mon_e.kc);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 80 && q.size() != 0; i++) wait_clk(1);
        check("pending_expectations", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    // bits[0] is the start bit; each bit is placed while kclock is high, then kclock falls.
    task automatic send_bits(input logic [10:0] bits, input int nfall, input int half, input bit glitch);
        for (int i = 0; i < nfall; i++) begin
            kdata = bits[i];
            if (glitch) begin
                wait_clk(6);
                kclock = 1'b0;
                wait_clk(2);
                kclock = 1'b1;
            end
            wait_clk(half);
            kclock = 1'b0;
            if (glitch) begin
                wait_clk(2);
                kdata = ~kdata;
                wait_clk(2);
                kdata = ~kdata;
                wait_clk(half - 4);
            end else begin
                wait_clk(half);
            end
            kclock = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int half, input bit glitch);
        logic        par;
        logic        stop;
        logic [10:0] bits;
        exp_t        e;
        par  = ~(^d) ^ bad_par;
        stop = ~bad_stop;
        bits = {stop, par, d, 1'b0};
        if (stop && ((($countones(d) + int'(par)) % 2) == 1)) begin
            m_hist = {m_hist[23:0], d};
            e.err  = 1'b0;
        end else begin
            e.err  = 1'b1;
        end
        e.kc = m_hist;
        q.push_back(e);
        send_bits(bits, 11, half, glitch);
        kdata = 1'b1;
        drain();
        wait_clk(half);
    endtask

    task automatic send_partial(input int nfall, input int half);
        logic [10:0] bits;
        exp_t        e;
        bits    = 11'($urandom);
        bits[0] = 1'b0;
        e.err   = 1'b1;
        e.kc    = m_hist;
        q.push_back(e);
        send_bits(bits, nfall, half, 1'b0);
        kdata = 1'b1;
        wait_clk(TMO + 5);
        drain();
        wait_clk(10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pbits;
        reset = 1'b1;
        wait_clk(3);
        check("reset_keycodeout", keycodeout, 32'd0);
        check("reset_valid", {31'd0, keycode_valid}, 32'd0);
        check("reset_error", {31'd0, frame_error}, 32'd0);
        reset = 1'b0;
        wait_clk(10);

        send_frame(8'h1C, 1'b0, 1'b0, 10, 1'b0);
        check("hist_after_1c", keycodeout, 32'h0000001C);
        send_frame(8'hF0, 1'b0, 1'b0, 10, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 10, 1'b0);
        check("hist_after_3", keycodeout, 32'h001CF01C);

        send_frame(8'h1C, 1'b1, 1'b0, 10, 1'b0);
        check("hist_after_bad_parity", keycodeout, 32'h001CF01C);
        send_frame(8'h29, 1'b0, 1'b0, 10, 1'b0);
        check("hist_after_29", keycodeout, 32'h1CF01C29);

        send_partial(4, 10);
        send_frame(8'h29, 1'b0, 1'b0, 10, 1'b0);
        check("low_byte_after_timeout", {24'd0, keycodeout[7:0]}, 32'h29);

        kclock = 1'b0;
        wait_clk(2);
        kclock = 1'b1;
        wait_clk(20);
        send_frame(8'h5A, 1'b0, 1'b0, 10, 1'b1);
        check("hist_after_glitchy_5a", keycodeout, 32'h1C29295A);

        pbits = 11'b11_1010_1100;
        send_bits(pbits, 5, 10, 1'b0);
        kdata = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        m_hist = 32'd0;
        q.delete();
        check("reset_midframe_keycodeout", keycodeout, 32'd0);
        wait_clk(20);
        send_frame(8'h1C, 1'b0, 1'b0, 10, 1'b0);
        check("hist_after_reset_1c", keycodeout, 32'h0000001C);

        for (int n = 0; n < 40; n++) begin
            int half_r;
            half_r = $urandom_range(8, 14);
            if ($urandom_range(0, 7) == 0) begin
                send_partial($urandom_range(1, 10), half_r);
            end else begin
                send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                           half_r, 1'($urandom_range(0, 1)));
            end
        end
        check("final_history", keycodeout, m_hist);

        wait_clk(20);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
